// File: rtl/rv_pkg.sv
// Shared fetch-side definitions: architectural widths, fetch FSM states, NOP encoding.
package rv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  // Force a fetch target onto an instruction-word boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(XLEN'(INSTR_BYTES) - XLEN'(1));
  endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch unit with a one-entry decode buffer.
module ifetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            kill_q, kill_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] target;

  // Next-state, pc and decode-buffer update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    target     = align_pc(redirect_pc);

    unique case (state_q)
      FS_IDLE: begin
        state_d = FS_REQ;
        if (redirect_valid) pc_d = target;
      end
      FS_REQ: begin
        if (imem_ack) begin
          if (kill_q || redirect_valid) begin
            kill_d = 1'b0;
            if (redirect_valid) pc_d = target;
          end else begin
            id_instr_d = imem_rdata;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
            pc_d       = pc_q + XLEN'(INSTR_BYTES);
            state_d    = FS_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      FS_HOLD: begin
        if (redirect_valid || id_ready) begin
          id_valid_d = 1'b0;
          state_d    = FS_REQ;
          if (redirect_valid) pc_d = target;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    // The issued address is frozen while a request is outstanding, so a
    // redirect moves pc but not the bus; otherwise it follows the next pc.
    addr_d = (state_q == FS_REQ && !imem_ack) ? addr_q : pc_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      kill_q     <= 1'b0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      kill_q     <= kill_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  // Registered outputs.
  always_comb begin
    imem_req  = (state_q == FS_REQ);
    imem_addr = addr_q;
    id_valid  = id_valid_q;
    id_pc     = id_pc_q;
    id_instr  = id_instr_q;
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed, table-driven bench for ifetch_unit plus a hand-written IDLE-redirect sequence.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
  );

  // Inputs applied for one cycle and the outputs expected just before that edge.
  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic a, input logic [31:0] rd,
                             input logic rv, input logic [31:0] rp, input logic rdy,
                             input logic q, input logic [31:0] ad, input logic vl,
                             input logic [31:0] ip, input logic [31:0] ins);
    vec_t t;
    t.rst = r;  t.ack = a;  t.rdata = rd; t.redir = rv; t.rpc = rp; t.ready = rdy;
    t.req = q;  t.addr = ad; t.valid = vl; t.ipc = ip;  t.instr = ins;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_row(input int idx, input vec_t t);
    check("imem_req", idx, {31'd0, imem_req}, {31'd0, t.req});
    check("imem_addr", idx, imem_addr, t.addr);
    check("id_valid", idx, {31'd0, id_valid}, {31'd0, t.valid});
    check("id_pc", idx, id_pc, t.ipc);
    check("id_instr", idx, id_instr, t.instr);
  endtask

  task automatic drive(input vec_t t);
    rst            = t.rst;
    imem_ack       = t.ack;
    imem_rdata     = t.rdata;
    redirect_valid = t.redir;
    redirect_pc    = t.rpc;
    id_ready       = t.ready;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    bit got;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);

    //       rst ack rdata         rv rpc           rdy | req addr          vl id_pc         id_instr
    // reset state, sequential fetch 0,4,8
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         0, 32'h0,         NOP));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h0,         0, 32'h0,         NOP));
    tbl.push_back(v(0, 1, 32'h1111_0000, 0, 32'h0,         1,  1, 32'h0,         0, 32'h0,         NOP));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h4,         1, 32'h0,         32'h1111_0000));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h4,         0, 32'h0,         32'h1111_0000));
    tbl.push_back(v(0, 1, 32'h2222_0004, 0, 32'h0,         1,  1, 32'h4,         0, 32'h0,         32'h1111_0000));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h8,         1, 32'h4,         32'h2222_0004));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h8,         0, 32'h4,         32'h2222_0004));
    tbl.push_back(v(0, 1, 32'h3333_0008, 0, 32'h0,         1,  1, 32'h8,         0, 32'h4,         32'h2222_0004));
    // decode stalled 5 cycles in HOLD; stray ack while req=0 ignored
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         0,  0, 32'hC,         1, 32'h8,         32'h3333_0008));
    tbl.push_back(v(0, 1, 32'hDEAD_DEAD, 0, 32'h0,         0,  0, 32'hC,         1, 32'h8,         32'h3333_0008));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         0,  0, 32'hC,         1, 32'h8,         32'h3333_0008));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         0,  0, 32'hC,         1, 32'h8,         32'h3333_0008));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         0,  0, 32'hC,         1, 32'h8,         32'h3333_0008));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'hC,         1, 32'h8,         32'h3333_0008));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'hC,         0, 32'h8,         32'h3333_0008));
    tbl.push_back(v(0, 1, 32'h4444_000C, 0, 32'h0,         1,  1, 32'hC,         0, 32'h8,         32'h3333_0008));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h10,        1, 32'hC,         32'h4444_000C));
    // redirect to 0x102 in REQ, ack 3 cycles later is dropped, then 0x100 fetched
    tbl.push_back(v(0, 0, 32'h0,         1, 32'h102,       1,  1, 32'h10,        0, 32'hC,         32'h4444_000C));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h10,        0, 32'hC,         32'h4444_000C));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h10,        0, 32'hC,         32'h4444_000C));
    tbl.push_back(v(0, 1, 32'hBAD0_0010, 0, 32'h0,         1,  1, 32'h10,        0, 32'hC,         32'h4444_000C));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h100,       0, 32'hC,         32'h4444_000C));
    tbl.push_back(v(0, 1, 32'h5555_0100, 0, 32'h0,         1,  1, 32'h100,       0, 32'hC,         32'h4444_000C));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h104,       1, 32'h100,       32'h5555_0100));
    // redirect coincident with ack, then second redirect before next ack
    tbl.push_back(v(0, 1, 32'hBAD1_0104, 1, 32'h200,       1,  1, 32'h104,       0, 32'h100,       32'h5555_0100));
    tbl.push_back(v(0, 0, 32'h0,         1, 32'h301,       1,  1, 32'h200,       0, 32'h100,       32'h5555_0100));
    tbl.push_back(v(0, 1, 32'hBAD2_0200, 0, 32'h0,         1,  1, 32'h200,       0, 32'h100,       32'h5555_0100));
    tbl.push_back(v(0, 1, 32'h6666_0300, 0, 32'h0,         1,  1, 32'h300,       0, 32'h100,       32'h5555_0100));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h304,       1, 32'h300,       32'h6666_0300));
    // redirect in HOLD to top of memory, then wrap to 0
    tbl.push_back(v(0, 1, 32'h7777_0304, 0, 32'h0,         1,  1, 32'h304,       0, 32'h300,       32'h6666_0300));
    tbl.push_back(v(0, 0, 32'h0,         1, 32'hFFFF_FFFF, 0,  0, 32'h308,       1, 32'h304,       32'h7777_0304));
    tbl.push_back(v(0, 1, 32'h8888_FFFC, 0, 32'h0,         1,  1, 32'hFFFF_FFFC, 0, 32'h304,       32'h7777_0304));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h0,         1, 32'hFFFF_FFFC, 32'h8888_FFFC));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h0,         0, 32'hFFFF_FFFC, 32'h8888_FFFC));
    tbl.push_back(v(0, 1, 32'h9999_0000, 0, 32'h0,         1,  1, 32'h0,         0, 32'hFFFF_FFFC, 32'h8888_FFFC));
    // transfer and redirect on the same edge
    tbl.push_back(v(0, 0, 32'h0,         1, 32'h400,       1,  0, 32'h4,         1, 32'h0,         32'h9999_0000));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h400,       0, 32'h0,         32'h9999_0000));
    // reset mid-request, ack arrives during reset, fetch restarts at RESET_PC
    tbl.push_back(v(1, 0, 32'h0,         0, 32'h0,         1,  1, 32'h400,       0, 32'h0,         32'h9999_0000));
    tbl.push_back(v(1, 1, 32'hBAD3_0400, 0, 32'h0,         1,  0, 32'h0,         0, 32'h0,         NOP));
    tbl.push_back(v(0, 1, 32'hBAD4_0400, 0, 32'h0,         1,  0, 32'h0,         0, 32'h0,         NOP));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  1, 32'h0,         0, 32'h0,         NOP));
    tbl.push_back(v(0, 1, 32'hAAAA_0000, 0, 32'h0,         1,  1, 32'h0,         0, 32'h0,         NOP));
    tbl.push_back(v(0, 0, 32'h0,         0, 32'h0,         1,  0, 32'h4,         1, 32'h0,         32'hAAAA_0000));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      check_row(i, tbl[i]);
      @(negedge clk);
    end

    // Redirect while in IDLE: first fetch goes to the aligned target.
    rst = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0503;
    #1;
    check("idle_req", 100, {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("idle_redir_req", 101, {31'd0, imem_req}, 32'd1);
    check("idle_redir_addr", 101, imem_addr, 32'h0000_0500);
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0500;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      got = id_valid;
    end
    check("idle_redir_valid", 102, {31'd0, got}, 32'd1);
    check("idle_redir_id_pc", 102, id_pc, 32'h0000_0500);
    check("idle_redir_instr", 102, id_instr, 32'hCAFE_0500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
